// File: rtl/serial_parity_framer_if.sv
// Word-input handshake for serial_parity_framer: in_data/in_valid from the
// producer, in_ready back from the framer. A word moves when valid && ready at a rising edge.
`timescale 1ns/1ps
interface serial_parity_framer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/serial_parity_framer.sv
// Parallel-to-serial framer: start, DATA_W data bits LSB-first, optional parity, stop.
// Parity bit and PARITY state exist only when SPF_PARITY_EN is defined.
`timescale 1ns/1ps
module serial_parity_framer #(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_parity_framer_if.slave in_if,
  output logic                  tx_bit,
  output logic                  bit_strobe,
  output logic                  busy,
  output logic                  frame_done,
  output logic [2:0]            dbg_state
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

  if (DATA_W < 1) begin : g_bad_data_w
    $error("serial_parity_framer: DATA_W must be at least 1");
  end
  if (BAUD_DIV < 1) begin : g_bad_baud_div
    $error("serial_parity_framer: BAUD_DIV must be at least 1");
  end
  if ((ODD_PARITY != 0) && (ODD_PARITY != 1)) begin : g_bad_odd_parity
    $error("serial_parity_framer: ODD_PARITY must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef SPF_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     baud_cnt, baud_nxt;
  logic [CW-1:0]     bit_cnt, bit_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              tx_nxt, strobe_nxt, done_nxt, bit_end;

`ifdef SPF_PARITY_EN
  localparam logic ODD_BIT = 1'(ODD_PARITY);
  logic par_q, par_nxt;
`endif

  assign bit_end         = (baud_cnt == BAUD_LAST);
  assign in_if.in_ready  = (state == IDLE);
  assign dbg_state       = state;

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
`ifdef SPF_PARITY_EN
    par_nxt   = par_q;
`endif
    if (state != IDLE) begin
      baud_nxt = bit_end ? '0 : baud_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        baud_nxt = '0;
        // in_ready is implied here, so in_valid alone completes the handshake
        if (in_if.in_valid) begin
          state_nxt = START;
          shreg_nxt = in_if.in_data;
`ifdef SPF_PARITY_EN
          par_nxt   = (^in_if.in_data) ^ ODD_BIT;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_nxt = shreg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_nxt = '0;
`ifdef SPF_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
`ifdef SPF_PARITY_EN
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Registered outputs are derived from the upcoming state so they line up
    // with the state register rather than trailing it by a cycle.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
`ifdef SPF_PARITY_EN
      PARITY:  tx_nxt = par_nxt;
`endif
      default: tx_nxt = 1'b1;
    endcase

    strobe_nxt = (state_nxt != IDLE) && ((state == IDLE) || bit_end);
    done_nxt   = (state_nxt == STOP) && (baud_nxt == BAUD_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx_bit     <= 1'b1;
      bit_strobe <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= shreg_nxt;
      tx_bit     <= tx_nxt;
      bit_strobe <= strobe_nxt;
      busy       <= (state_nxt != IDLE);
      frame_done <= done_nxt;
    end
  end

`ifdef SPF_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_nxt;
  end
`endif

  a_busy_state:   assert property (@(posedge clk) disable iff (rst) busy == (state != IDLE));
  a_strobe_frame: assert property (@(posedge clk) disable iff (rst) bit_strobe |-> (state != IDLE));
  a_done_stop:    assert property (@(posedge clk) disable iff (rst) frame_done |-> (state == STOP));
  a_start_low:    assert property (@(posedge clk) disable iff (rst) (state == START) |-> !tx_bit);
  a_idle_high:    assert property (@(posedge clk) disable iff (rst) ((state == IDLE) || (state == STOP)) |-> tx_bit);
  a_baud_range:   assert property (@(posedge clk) disable iff (rst) baud_cnt <= BAUD_LAST);

endmodule

// File: tb/tb_serial_parity_framer.sv
// Bench for serial_parity_framer: two instances (BAUD_DIV 1 even, BAUD_DIV 4 odd),
// directed words with hand-derived frames checked by per-instance frame monitors.
`timescale 1ns/1ps
module tb_serial_parity_framer;
  localparam int DW = 8;
`ifdef SPF_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_parity_framer_if #(.DATA_W(DW)) if0 ();
  serial_parity_framer_if #(.DATA_W(DW)) if1 ();
  logic tx0, stb0, busy0, done0, tx1, stb1, busy1, done1;
  logic [2:0] st0, st1;

  serial_parity_framer #(.DATA_W(DW), .BAUD_DIV(1), .ODD_PARITY(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_if(if0), .tx_bit(tx0), .bit_strobe(stb0),
    .busy(busy0), .frame_done(done0), .dbg_state(st0));
  serial_parity_framer #(.DATA_W(DW), .BAUD_DIV(4), .ODD_PARITY(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_if(if1), .tx_bit(tx1), .bit_strobe(stb1),
    .busy(busy1), .frame_done(done1), .dbg_state(st1));

  logic [1:0] tx_a, stb_a, busy_a, done_a, rdy_a;
  assign tx_a   = {tx1, tx0};
  assign stb_a  = {stb1, stb0};
  assign busy_a = {busy1, busy0};
  assign done_a = {done1, done0};
  assign rdy_a  = {if1.in_ready, if0.in_ready};

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [FB:0] exp_q[$];
  int          start_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [FB-1:0] mk_frame(input logic [7:0] d, input logic p);
`ifdef SPF_PARITY_EN
    return {1'b1, p, d, 1'b0};
`else
    logic unused_par;
    unused_par = p;
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // driver
  task automatic send(input int u, input logic [7:0] d, input logic p,
                      input bit keep, input bit push, output int hs);
    @(negedge clk);
    if (u == 0) begin if0.in_data = d; if0.in_valid = 1'b1; end
    else        begin if1.in_data = d; if1.in_valid = 1'b1; end
    hs = -1;
    for (int i = 0; i < 400; i++) begin
      if ((u == 0) ? if0.in_ready : if1.in_ready) begin
        hs = cyc;
        break;
      end
      @(negedge clk);
    end
    if (hs < 0) begin
      check("handshake_timeout", 32'd0, 32'd1);
    end else if (push) begin
      exp_q.push_back({u[0], mk_frame(d, p)});
      start_q.push_back(hs + 1);
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      if (u == 0) if0.in_valid = 1'b0;
      else        if1.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // monitors: rebuild each frame from bit_strobe/tx_bit and compare on frame_done
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int BAUD = (g == 0) ? 1 : 4;
    bit in_frame = 1'b0;
    bit chk_after = 1'b0;
    logic [FB-1:0] got;
    logic cur;
    int nbits, len, plen, viol, start_c;
    logic [FB:0] e;
    int s;
    always @(negedge clk) begin
      if (rst) begin
        in_frame  = 1'b0;
        chk_after = 1'b0;
      end else begin
        if (!in_frame && chk_after) begin
          check($sformatf("u%0d_ready_after_done", g), 32'(rdy_a[g]), 32'd1);
          check($sformatf("u%0d_idle_tx_after_done", g), 32'(tx_a[g]), 32'd1);
          chk_after = 1'b0;
        end
        if (!in_frame && stb_a[g]) begin
          in_frame = 1'b1; got = '0; nbits = 0; len = 0; plen = 0; viol = 0; start_c = cyc;
        end
        if (in_frame) begin
          len++;
          if (stb_a[g]) begin
            if (nbits > 0 && plen != BAUD) viol++;
            if (nbits < FB) got[nbits] = tx_a[g];
            nbits++;
            plen = 1;
            cur = tx_a[g];
          end else begin
            plen++;
            if (tx_a[g] !== cur) viol++;
          end
          if (!busy_a[g] || rdy_a[g]) viol++;
          if (done_a[g]) begin
            if (plen != BAUD) viol++;
            if (exp_q.size() == 0) begin
              check($sformatf("u%0d_unexpected_frame_done", g), 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              s = start_q.pop_front();
              check($sformatf("u%0d_frame_unit", g), 32'(e[FB]), 32'(g));
              check($sformatf("u%0d_frame_bits", g), 32'(got), 32'(e[FB-1:0]));
              check($sformatf("u%0d_strobe_count", g), 32'(nbits), 32'(FB));
              check($sformatf("u%0d_frame_len", g), 32'(len), 32'(BAUD * FB));
              check($sformatf("u%0d_start_cycle", g), 32'(start_c), 32'(s));
              check($sformatf("u%0d_timing_viol", g), 32'(viol), 32'd0);
            end
            in_frame  = 1'b0;
            chk_after = 1'b1;
          end
        end else if (done_a[g]) begin
          check($sformatf("u%0d_frame_done_outside_frame", g), 32'd1, 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // directed sequence
  initial begin
    int hs, hs2;
    if0.in_valid = 1'b0; if0.in_data = '0;
    if1.in_valid = 1'b0; if1.in_data = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx0", 32'(tx0), 32'd1);
    check("rst_stb0", 32'(stb0), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_done0", 32'(done0), 32'd0);
    check("rst_ready0", 32'(if0.in_ready), 32'd1);
    check("rst_state0", 32'(st0), 32'd0);
    check("rst_tx1", 32'(tx1), 32'd1);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_ready1", 32'(if1.in_ready), 32'd1);
    check("rst_state1", 32'(st1), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    // BAUD_DIV 1, even parity; parity bits hand-counted from popcounts
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1, hs); wait_drain();
    send(0, 8'hFF, 1'b0, 1'b0, 1'b1, hs); wait_drain();
    send(0, 8'h00, 1'b0, 1'b0, 1'b1, hs); wait_drain();

    // back-to-back with in_valid held; in_data changed mid-frame must not leak
    send(0, 8'h12, 1'b0, 1'b1, 1'b1, hs);
    if0.in_data = 8'h34;
    send(0, 8'h34, 1'b1, 1'b0, 1'b1, hs2);
    check("b2b_handshake_gap", 32'(hs2 - hs), 32'(FB + 1));
    wait_drain();

    // reset during data bit 3 (starts at cycle hs+5 for BAUD_DIV 1)
    send(0, 8'h96, 1'b0, 1'b0, 1'b0, hs);
    for (int i = 0; i < 20; i++) begin
      if (cyc == hs + 5) break;
      @(negedge clk);
    end
    check("abort_in_data_state", 32'(st0), 32'd2);
    #1 rst = 1'b1;
    #1;
    check("abort_tx", 32'(tx0), 32'd1);
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_ready", 32'(if0.in_ready), 32'd1);
    check("abort_strobe", 32'(stb0), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1, hs); wait_drain();

    // BAUD_DIV 4, odd parity
    send(1, 8'hFF, 1'b1, 1'b0, 1'b1, hs); wait_drain();
    send(1, 8'h01, 1'b0, 1'b0, 1'b1, hs); wait_drain();
    send(1, 8'h00, 1'b1, 1'b0, 1'b1, hs); wait_drain();
    send(1, 8'h80, 1'b0, 1'b0, 1'b1, hs); wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_parity_framer.md
# serial_parity_framer

Upstream feeder for the serial parity-generation and checking stages. It accepts a parallel word over a valid/ready handshake and shifts it onto a 1-bit serial line, LSB-first. Each frame is a start bit, DATA_W data bits, an optional parity bit and a stop bit, with every bit held for BAUD_DIV clocks. Its tx_bit output drives the serial input of the downstream bit-serial FSM.

## Interface
- DATA_W, 8: data bits per frame; minimum 1.
- BAUD_DIV, 1: clocks per serial bit; minimum 1.
- ODD_PARITY, 0: 0 selects even parity, 1 selects odd.
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  DATA_W  word to transmit; sampled only on handshake.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  framer can accept a word; high exactly when state is IDLE.
- tx_bit  output  1  serial line; idles high; registered.
- bit_strobe  output  1  one-cycle pulse on the first cycle of every transmitted bit period (start, data, parity, stop); registered.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- A handshake occurs when in_valid and in_ready are both high at a rising edge.
  - in_data is latched into the shift register.
  - Parity is computed as ^in_data XOR ODD_PARITY and latched.
  - The next state is START.
- Transitions:
  - START goes to DATA after BAUD_DIV cycles.
  - DATA transmits shreg[0] and shifts right once per bit period. It lasts DATA_W periods, tracked by a bit counter of width clog2(DATA_W+1).
  - DATA then goes to PARITY, or straight to STOP when parity is compiled out.
  - PARITY lasts 1 period, then goes to STOP.
  - STOP lasts 1 period, then goes to IDLE.
- Line levels: START = 0, DATA = data bit, PARITY = latched parity, STOP = 1, IDLE = 1.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and is clog2(BAUD_DIV)-bit, minimum 1 bit.
  - Wraps to 0 at each bit boundary.
  - Is held at 0 in IDLE.
- in_valid while busy is ignored, and the word is not captured. The upstream must hold in_valid until it sees in_ready.
- in_data changing mid-frame has no effect.
- Reset mid-frame: the frame is abandoned immediately.
  - tx_bit goes to 1 and state to IDLE.
  - No frame_done pulse is produced.
  - The receiver sees a truncated frame; this is acceptable.
- Reset values: state IDLE, tx_bit 1, bit_strobe 0, busy 0, frame_done 0, in_ready 1, all counters and shift register 0.

## Timing
- Take the handshake at edge k.
  - tx_bit = 0 and bit_strobe = 1 in cycle k+1.
  - Data bit i starts at cycle k+1+BAUD_DIV*(1+i).
  - Parity starts at cycle k+1+BAUD_DIV*(1+DATA_W).
  - Stop starts at k+1+BAUD_DIV*(2+DATA_W).
- Frame length is BAUD_DIV*(DATA_W+3) cycles with parity, BAUD_DIV*(DATA_W+2) without.
- frame_done is asserted in the final stop cycle. in_ready rises the following cycle, when state is IDLE.
- Back-to-back frames have a minimum of 1 idle cycle (tx_bit = 1) between stop and the next start.
- bit_strobe and frame_done are never high outside a frame.
- With BAUD_DIV = 1 and DATA_W = 1, a one-cycle-per-bit frame of length 4 is the minimum case.
- in_ready is combinational from state (no input-to-output path). All other outputs are registered.

## Configuration
- SPF_PARITY_EN:
  - Defined: the PARITY state exists and parity is generated per ODD_PARITY.
  - Undefined: the PARITY state, the parity register and the ODD_PARITY logic are removed. DATA goes directly to STOP, the frame is BAUD_DIV*(DATA_W+2) cycles, and ODD_PARITY is ignored.

## Test plan
- Even parity, SPF_PARITY_EN on, DATA_W=8, BAUD_DIV=1, in_data=0xA5 -> tx_bit sequence 0,1,0,1,0,0,1,0,1,0,1 over cycles k+1..k+11; frame_done at k+11; in_ready high at k+12.
- ODD_PARITY=1, in_data=0x01 -> parity bit 0. With in_data=0x00 -> parity bit 1.
- BAUD_DIV=4, in_data=0xFF -> each level held exactly 4 cycles; 11 bit_strobe pulses spaced 4 cycles apart; frame length 44 cycles.
- in_valid held high continuously with 0x12 then 0x34 -> second word accepted only at the edge after frame_done; exactly 1 idle-high cycle between frames; 0x34 not captured during the first frame.
- rst asserted during data bit 3 -> tx_bit = 1, busy = 0, in_ready = 1 immediately; no frame_done; next handshake produces a complete, correct frame.
- SPF_PARITY_EN undefined, DATA_W=8, BAUD_DIV=1, in_data=0xA5 -> 10-cycle frame 0,1,0,1,0,0,1,0,1,1; frame_done at k+10.
